// File: rtl/cache_fill_controller_if.sv
// Signal bundle between the miss handler and the caches, the pipeline and main memory.
// Miss counter signals exist only when CFC_MISS_COUNTERS_EN is defined.
interface cache_fill_controller_if #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 8
);
    localparam int IDX_W = $clog2(WORDS_PER_BLK);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              fill_we;
    logic              fill_sel;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              tag_we;
    logic [ADDR_W-1:0] fill_base;
    logic              i_stall;
    logic              d_stall;
    logic              busy;
`ifdef CFC_MISS_COUNTERS_EN
    logic [15:0]       i_miss_cnt;
    logic [15:0]       d_miss_cnt;
`endif

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rvalid, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_we, fill_sel, fill_idx, fill_data, tag_we, fill_base,
        output i_stall, d_stall, busy
`ifdef CFC_MISS_COUNTERS_EN
        , output i_miss_cnt, d_miss_cnt
`endif
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_rvalid, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_we, fill_sel, fill_idx, fill_data, tag_we, fill_base,
        input  i_stall, d_stall, busy
`ifdef CFC_MISS_COUNTERS_EN
        , input i_miss_cnt, d_miss_cnt
`endif
    );
endinterface

// File: rtl/cache_fill_controller.sv
// Cache miss handler: arbitrates stores and I/D misses, streams a block from pipelined memory.
// Optional per-side miss counters are enabled with CFC_MISS_COUNTERS_EN.
module cache_fill_controller #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 8,
    parameter int MEM_LAT       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cache_fill_controller_if.master bus
);
    localparam int                IDX_W    = $clog2(WORDS_PER_BLK);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << (IDX_W + 1)) - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);

    if (WORDS_PER_BLK < 2 || (WORDS_PER_BLK & (WORDS_PER_BLK - 1)) != 0 || MEM_LAT < 0) begin : g_param_chk
        $error("cache_fill_controller: WORDS_PER_BLK must be a power of 2 >= 2, MEM_LAT >= 0");
    end

    typedef enum logic [2:0] {IDLE, WRITE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              sel_q;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  iss_cnt_q;
    logic [IDX_W-1:0]  ret_cnt_q;

    logic              ret_take;
    logic              ret_last;
    logic              start_fill;
    logic              mem_en, mem_wr, tag_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_we    = 1'b0;
        ret_take  = bus.mem_rvalid && (state_q == ISSUE || state_q == DRAIN);
        ret_last  = ret_take && (ret_cnt_q == LAST_IDX);
        unique case (state_q)
            IDLE: begin
                if (bus.d_wr_req)
                    state_d = WRITE;
                else if (bus.d_miss || bus.i_miss)
                    state_d = ISSUE;
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = bus.d_wr_addr;
                mem_wdata = bus.d_wr_data;
                state_d   = IDLE;
            end
            ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = base_q + ADDR_W'({iss_cnt_q, 1'b0});
                // A return completing the block wins over the move to DRAIN
                if (ret_last)
                    state_d = DONE;
                else if (iss_cnt_q == LAST_IDX)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (ret_last)
                    state_d = DONE;
            end
            DONE: begin
                tag_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_fill = (state_q == IDLE) && (state_d == ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            base_q    <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_fill) begin
                sel_q     <= bus.d_miss;
                base_q    <= (bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr) & ~OFF_MASK;
                iss_cnt_q <= '0;
                ret_cnt_q <= '0;
            end else begin
                if (state_q == ISSUE)
                    iss_cnt_q <= iss_cnt_q + 1'b1;
                if (ret_take)
                    ret_cnt_q <= ret_cnt_q + 1'b1;
            end
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.fill_we   = ret_take;
    assign bus.fill_idx  = ret_take ? ret_cnt_q : '0;
    assign bus.fill_data = ret_take ? bus.mem_rdata : '0;
    assign bus.fill_sel  = sel_q;
    assign bus.fill_base = base_q;
    assign bus.tag_we    = tag_we;
    assign bus.busy      = (state_q != IDLE);

    // A stall drops only in the DONE cycle of its own fill; stores wait until they own the bus
    assign bus.i_stall = bus.i_miss & ~((state_q == DONE) & ~sel_q);
    assign bus.d_stall = (bus.d_miss & ~((state_q == DONE) & sel_q))
                       | (bus.d_wr_req & (state_q != WRITE));

`ifdef CFC_MISS_COUNTERS_EN
    logic [15:0] i_cnt_q, d_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else if (start_fill) begin
            if (bus.d_miss) begin
                if (d_cnt_q != 16'hFFFF)
                    d_cnt_q <= d_cnt_q + 16'd1;
            end else if (i_cnt_q != 16'hFFFF) begin
                i_cnt_q <= i_cnt_q + 16'd1;
            end
        end
    end

    assign bus.i_miss_cnt = i_cnt_q;
    assign bus.d_miss_cnt = d_cnt_q;
`endif
endmodule

// File: tb/tb_cache_fill_controller.sv
// Scoreboard bench for cache_fill_controller with a 4-cycle pipelined memory model.
// Counter checks are compiled in when CFC_MISS_COUNTERS_EN is defined.
module tb_cache_fill_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_fill_controller_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8)) bus ();

    cache_fill_controller #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8), .MEM_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory: read issued in cycle c returns in cycle c+4 with data addr ^ 16'h5A5A
    logic [3:0]  pv = '0;
    logic [15:0] pd [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
        pd[0] <= bus.mem_addr ^ 16'h5A5A;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign bus.mem_rvalid = pv[3];
    assign bus.mem_rdata  = pd[3];

    typedef struct { logic wr; logic [15:0] addr; logic [15:0] data; } mem_t;
    typedef struct { logic sel; logic [2:0] idx; logic [15:0] data; } fill_t;
    typedef struct { logic sel; logic [15:0] base; } tag_t;
    mem_t  mem_q[$];
    fill_t fill_q[$];
    tag_t  tag_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [95:0] outs();
        return {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_we, bus.fill_sel,
                bus.fill_idx, bus.fill_data, bus.tag_we, bus.fill_base, bus.i_stall, bus.d_stall, bus.busy};
    endfunction

    task automatic push_fill(input logic sel, input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            a = base + 16'(2 * k);
            mem_q.push_back('{wr: 1'b0, addr: a, data: 16'h0});
            fill_q.push_back('{sel: sel, idx: 3'(k), data: a ^ 16'h5A5A});
        end
        tag_q.push_back('{sel: sel, base: base});
    endtask

    task automatic check_drained(input string name);
        check(mem_q.size() == 0 && fill_q.size() == 0 && tag_q.size() == 0, name,
              {mem_q.size(), fill_q.size(), tag_q.size()}, 0);
    endtask

    // Monitor: every DUT output event is matched against the head of its queue
    mem_t  m;
    fill_t f;
    tag_t  t;
    always @(negedge clk) begin
        if (bus.mem_en) begin
            if (mem_q.size() == 0) begin
                check(1'b0, "mem_unexpected", {bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 0);
            end else begin
                m = mem_q.pop_front();
                check(bus.mem_wr == m.wr && bus.mem_addr == m.addr && (!m.wr || bus.mem_wdata == m.data),
                      "mem_req", {bus.mem_wr, bus.mem_addr, m.wr ? bus.mem_wdata : 16'h0},
                      {m.wr, m.addr, m.data});
            end
        end
        if (bus.fill_we) begin
            if (fill_q.size() == 0) begin
                check(1'b0, "fill_unexpected", {bus.fill_sel, bus.fill_idx, bus.fill_data}, 0);
            end else begin
                f = fill_q.pop_front();
                check(bus.fill_sel == f.sel && bus.fill_idx == f.idx && bus.fill_data == f.data,
                      "fill_write", {bus.fill_sel, bus.fill_idx, bus.fill_data}, {f.sel, f.idx, f.data});
            end
        end
        if (bus.tag_we) begin
            if (tag_q.size() == 0) begin
                check(1'b0, "tag_unexpected", {bus.fill_sel, bus.fill_base}, 0);
            end else begin
                t = tag_q.pop_front();
                check(bus.fill_sel == t.sel && bus.fill_base == t.base, "tag_commit",
                      {bus.fill_sel, bus.fill_base}, {t.sel, t.base});
            end
        end
    end

    task automatic run_miss(input logic sel, input logic [15:0] addr);
        int n;
        push_fill(sel, addr);
        if (sel) begin bus.d_miss = 1'b1; bus.d_miss_addr = addr; end
        else     begin bus.i_miss = 1'b1; bus.i_miss_addr = addr; end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((sel ? bus.d_stall : bus.i_stall) && n < 40);
        check(n == 13, sel ? "d_stall_release" : "i_stall_release", n, 13);
        bus.d_miss = 1'b0;
        bus.i_miss = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ihi, dhi, seen, bad;
        logic [95:0] acc;
        bus.i_miss = 0; bus.i_miss_addr = 0; bus.d_miss = 0; bus.d_miss_addr = 0;
        bus.d_wr_req = 0; bus.d_wr_addr = 0; bus.d_wr_data = 0;

        // Test 1: reset and idle
        repeat (3) @(posedge clk);
        #1;
        check(outs() == 0, "reset_outputs", outs(), 0);
        rst_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            acc |= outs();
        end
        check(acc == 0, "idle_outputs", acc, 0);

        // Test 2: single I miss
        run_miss(1'b0, 16'h1236);
        repeat (2) @(posedge clk);
        #1;
        check_drained("drained_i_fill");

        // Test 3: simultaneous I and D miss, D first
        push_fill(1'b1, 16'h0010);
        push_fill(1'b0, 16'h2008);
        bus.d_miss = 1'b1; bus.d_miss_addr = 16'h0010;
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h2008;
        ihi = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            ihi &= bus.i_stall;
        end while (bus.d_stall && n < 40);
        check(n == 13, "d_first_release", n, 13);
        check(ihi, "i_stall_during_d", ihi, 1);
        bus.d_miss = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.i_stall && n < 40);
        check(n == 14, "i_after_d_release", n, 14);
        bus.i_miss = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_drained("drained_id_fill");

        // Test 4: store arrives during an I fill
        push_fill(1'b0, 16'h3000);
        mem_q.push_back('{wr: 1'b1, addr: 16'h0400, data: 16'hBEEF});
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h3000;
        dhi = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (i >= 4 && i <= 14) dhi &= bus.d_stall;
            if (i == 3) begin
                bus.d_wr_req = 1'b1; bus.d_wr_addr = 16'h0400; bus.d_wr_data = 16'hBEEF;
            end
            if (i == 13) begin
                check(!bus.i_stall, "i_release_with_store", bus.i_stall, 0);
                bus.i_miss = 1'b0;
            end
            if (i == 15) begin
                check(!bus.d_stall && bus.mem_en && bus.mem_wr, "store_write_cycle",
                      {bus.d_stall, bus.mem_en, bus.mem_wr}, 3'b011);
                bus.d_wr_req = 1'b0;
            end
        end
        check(dhi, "d_stall_until_idle", dhi, 1);
        repeat (2) @(posedge clk);
        #1;
        check_drained("drained_store");

        // Test 5: reset after three returns aborts the fill
        for (int k = 0; k < 7; k++)
            mem_q.push_back('{wr: 1'b0, addr: 16'h4000 + 16'(2 * k), data: 16'h0});
        for (int k = 0; k < 3; k++)
            fill_q.push_back('{sel: 1'b0, idx: 3'(k), data: (16'h4000 + 16'(2 * k)) ^ 16'h5A5A});
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h4002;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.i_miss = 1'b0;
        #1;
        check(outs() == 0, "reset_abort_outputs", outs(), 0);
        seen = 1'b0;
        bad  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst_n = 1'b1;
            seen |= bus.mem_rvalid;
            bad  |= bus.fill_we | bus.tag_we;
        end
        check(seen && !bad, "late_rvalid_ignored", {seen, bad}, 2'b10);
        check_drained("drained_abort");

`ifdef CFC_MISS_COUNTERS_EN
        // Test 6: miss counters
        check(bus.i_miss_cnt == 0 && bus.d_miss_cnt == 0, "cnt_after_reset",
              {bus.i_miss_cnt, bus.d_miss_cnt}, 0);
        run_miss(1'b1, 16'h0100);
        run_miss(1'b1, 16'h0200);
        run_miss(1'b1, 16'h0300);
        run_miss(1'b0, 16'h0500);
        check(bus.d_miss_cnt == 16'd3, "d_miss_cnt", bus.d_miss_cnt, 3);
        check(bus.i_miss_cnt == 16'd1, "i_miss_cnt", bus.i_miss_cnt, 1);
        repeat (2) @(posedge clk);
        #1;
        check_drained("drained_counters");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
